// File: rtl/key_controller_if.sv
// key_controller_if: shared processor bus (tristate data, address, write enable) seen by the KEY peripheral.
interface key_controller_if #(parameter int DBITS = 32);
   wire  [DBITS-1:0] dbus;
   logic [DBITS-1:0] address;
   logic             wrtEn;
   modport master (inout dbus, output address, output wrtEn);
   modport slave  (inout dbus, input address, input wrtEn);
endinterface

// File: rtl/key_controller.sv
// key_controller: memory-mapped KEY input with synchronizer, per-key debounce and sticky ready/overrun flags.
// Build option KEY_CONTROLLER_INTR_EN adds the ie control bit and a registered intr output.
module key_controller #(
   parameter int               DBITS           = 32,
   parameter logic [DBITS-1:0] KDATA_ADDR      = 'hF000_0010,
   parameter logic [DBITS-1:0] KCTRL_ADDR      = 'hF000_0110,
   parameter int               NKEYS           = 4,
   parameter int               DEBOUNCE_CYCLES = 100000
) (
   input  logic             clk,
   input  logic             reset,
   key_controller_if.slave  bus,
   input  logic [NKEYS-1:0] KEY,
   output logic             intr
);
   localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
   logic [NKEYS-1:0] kmeta, ksync, kdata, kdata_q;
   logic [CW-1:0]    cnt [NKEYS];
   logic             ready, overrun, ie, kchange, rd_data, rd_ctrl, wr_ctrl;
   logic [DBITS-1:0] status;
   assign rd_data = bus.address == KDATA_ADDR && !bus.wrtEn;
   assign rd_ctrl = bus.address == KCTRL_ADDR && !bus.wrtEn;
   assign wr_ctrl = bus.address == KCTRL_ADDR && bus.wrtEn;
   assign kchange = kdata != kdata_q;
   always_comb begin
      status    = '0;
      status[0] = ready;
      status[2] = overrun;
      status[8] = ie;
   end
   assign bus.dbus = rd_data ? DBITS'(kdata) : rd_ctrl ? status : 'z;
   // Any sample that matches the accepted value restarts that key's count.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         kmeta   <= '1;
         ksync   <= '1;
         kdata   <= '0;
         kdata_q <= '0;
         for (int i = 0; i < NKEYS; i++) cnt[i] <= '0;
      end else begin
         kmeta   <= ~KEY;
         ksync   <= kmeta;
         kdata_q <= kdata;
         for (int i = 0; i < NKEYS; i++)
            if (ksync[i] == kdata[i]) cnt[i] <= '0;
            else if (cnt[i] == CMAX) begin
               kdata[i] <= ksync[i];
               cnt[i]   <= '0;
            end else cnt[i] <= cnt[i] + CW'(1);
      end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         ready   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         ready   <= kchange | (ready & ~rd_data);
         overrun <= (kchange & ready) | (overrun & ~(wr_ctrl & ~bus.dbus[2]));
      end
`ifdef KEY_CONTROLLER_INTR_EN
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         ie   <= 1'b0;
         intr <= 1'b0;
      end else begin
         if (wr_ctrl) ie <= bus.dbus[8];
         intr <= ready & ie;
      end
`else
   assign ie   = 1'b0;
   assign intr = 1'b0;
`endif
endmodule

// File: tb/tb_key_controller.sv
// tb_key_controller: directed plus randomized bus/KEY stimulus, checked by a scoreboard against a window-based reference model.
module tb_key_controller;
   localparam int          DBITS = 32, NKEYS = 4, DEB = 4;
   localparam logic [31:0] KDATA_ADDR = 32'hF000_0010, KCTRL_ADDR = 32'hF000_0110, IDLE_ADDR = 32'h0;
`ifdef KEY_CONTROLLER_INTR_EN
   localparam logic [31:0] IEV = 32'h100;
   localparam logic        IEB = 1'b1;
`else
   localparam logic [31:0] IEV = 32'h0;
   localparam logic        IEB = 1'b0;
`endif
   typedef struct {string name; logic [31:0] exp; bit is_intr;} chk_t;
   logic clk = 0, reset = 0, intr, act = 0, tb_en = 0;
   logic [3:0]  KEY = '1;
   logic [31:0] tb_val = '0;
   chk_t        q[$];
   int          total = 0, passed = 0;
   key_controller_if #(.DBITS(DBITS)) bus();
   assign bus.dbus = tb_en ? tb_val : 'z;
   key_controller #(.DBITS(DBITS), .KDATA_ADDR(KDATA_ADDR), .KCTRL_ADDR(KCTRL_ADDR), .NKEYS(NKEYS), .DEBOUNCE_CYCLES(DEB))
      dut (.clk(clk), .reset(reset), .bus(bus), .KEY(KEY), .intr(intr));
   always #5 clk = ~clk;
   // Reference model: a key is accepted once its last DEB synchronized samples all differ from the accepted value.
   logic [1:0][3:0]     m_pipe;
   logic [DEB-2:0][3:0] m_hist;
   int                  m_len;
   logic [3:0]          m_kdata;
   logic                m_chg, m_ready, m_ovr, m_ie, m_intr;
   function automatic logic [3:0] debounce(input logic [3:0] cur, input logic [DEB-2:0][3:0] past, input int len, input logic [3:0] kd);
      logic held;
      debounce = kd;
      for (int i = 0; i < NKEYS; i++) begin
         held = len >= DEB - 1 && cur[i] != kd[i];
         for (int j = 0; j < DEB - 1; j++) if (past[j][i] == kd[i]) held = 0;
         if (held) debounce[i] = cur[i];
      end
   endfunction
   function automatic logic [31:0] m_status();
      return {23'b0, m_ie, 5'b0, m_ovr, 1'b0, m_ready};
   endfunction
   always @(posedge clk or negedge reset)
      if (!reset) begin
         m_pipe <= '1; m_hist <= '0; m_len <= 0; m_kdata <= '0;
         m_chg <= 0; m_ready <= 0; m_ovr <= 0; m_ie <= 0; m_intr <= 0;
      end else begin
         m_pipe  <= {m_pipe[0], ~KEY};
         m_hist  <= {m_hist[DEB-3:0], m_pipe[1]};
         m_len   <= m_len < DEB - 1 ? m_len + 1 : m_len;
         m_kdata <= debounce(m_pipe[1], m_hist, m_len, m_kdata);
         m_chg   <= debounce(m_pipe[1], m_hist, m_len, m_kdata) != m_kdata;
         m_ready <= m_chg ? 1'b1 : (bus.address == KDATA_ADDR && !bus.wrtEn) ? 1'b0 : m_ready;
         m_ovr   <= (m_chg && m_ready) ? 1'b1 : (bus.address == KCTRL_ADDR && bus.wrtEn && !tb_val[2]) ? 1'b0 : m_ovr;
         m_ie    <= (bus.address == KCTRL_ADDR && bus.wrtEn) ? tb_val[8] & IEB : m_ie;
         m_intr  <= m_ready & m_ie;
      end
   initial forever begin
      @(negedge clk);
      #3;
      if (act) begin
         chk_t c;
         logic [31:0] got;
         total++;
         if (q.size() == 0) $display("FAIL scoreboard: no expected entry, got dbus=%h intr=%b", bus.dbus, intr);
         else begin
            c = q.pop_front();
            got = c.is_intr ? {31'b0, intr} : bus.dbus;
            if (got === c.exp) passed++;
            else $display("FAIL %s: got %h, expected %h", c.name, got, c.exp);
         end
      end
   end
   task automatic step(input logic [31:0] addr, input logic we, input logic en, input logic [31:0] val);
      @(negedge clk);
      bus.address = addr; bus.wrtEn = we; tb_en = en; tb_val = val; act = 0;
   endtask
   task automatic push(input string name, input logic [31:0] exp, input bit is_intr);
      chk_t c;
      c.name = name; c.exp = exp; c.is_intr = is_intr;
      q.push_back(c);
      act = 1;
   endtask
   task automatic idle(); step(IDLE_ADDR, 0, 0, 0); endtask
   task automatic cyc(input int n); repeat (n) idle(); endtask
   task automatic press(input logic [3:0] k); idle(); KEY = k; endtask
   task automatic wr(input logic [31:0] v); step(KCTRL_ADDR, 1, 1, v); endtask
   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
      step(addr, 0, 0, 0); push(name, exp, 0);
   endtask
   task automatic rdm(input logic [31:0] addr, input string name);
      step(addr, 0, 0, 0); push(name, addr == KDATA_ADDR ? {28'b0, m_kdata} : m_status(), 0);
   endtask
   task automatic hiz(input logic [31:0] addr, input logic we, input string name);
      step(addr, we, 1, 0); push(name, 0, 0);
   endtask
   task automatic ichk(input logic exp, input string name); idle(); push(name, {31'b0, exp}, 1); endtask
   initial begin
      bus.address = IDLE_ADDR; bus.wrtEn = 0;
      cyc(2);
      idle(); reset = 1;
      rd(KDATA_ADDR, 0, "rst_kdata");
      rd(KCTRL_ADDR, 0, "rst_kctrl");
      hiz(32'hF000_0020, 0, "hiz_nomatch");
      ichk(0, "rst_intr");
      press(4'b1110); cyc(4);
      rd(KDATA_ADDR, 0, "press_early");
      rd(KDATA_ADDR, 1, "press_latency");
      rd(KCTRL_ADDR, 1, "collision_ready");
      rd(KDATA_ADDR, 1, "press_kdata");
      rd(KCTRL_ADDR, 0, "read_clears_ready");
      hiz(KDATA_ADDR, 1, "hiz_write");
      repeat (10) begin press(KEY ^ 4'b0010); idle(); end
      cyc(8);
      rd(KCTRL_ADDR, 0, "bounce_ready");
      rd(KDATA_ADDR, 1, "bounce_kdata");
      press(4'b1010); cyc(8);
      press(4'b1110); cyc(8);
      rd(KCTRL_ADDR, 5, "overrun_set");
      wr(32'h4);
      rd(KCTRL_ADDR, 5, "overrun_w1_keep");
      wr(32'h0);
      rd(KCTRL_ADDR, 1, "overrun_clear");
      rd(KDATA_ADDR, 1, "overrun_kdata");
      rd(KCTRL_ADDR, 0, "overrun_ready_clr");
      wr(32'h100);
      rd(KCTRL_ADDR, IEV, "ie_readback");
      press(4'b0110); cyc(6);
      ichk(0, "intr_lag");
      ichk(IEB, "intr_set");
      rd(KDATA_ADDR, 9, "intr_kdata");
      ichk(IEB, "intr_hold");
      ichk(0, "intr_clear");
      press(4'b1111); cyc(8);
      rd(KDATA_ADDR, 0, "release_kdata");
      press(4'b1110); cyc(2);
      idle(); reset = 0;
      cyc(1);
      idle(); reset = 1;
      rd(KCTRL_ADDR, 0, "rst_mid_ctrl");
      rd(KDATA_ADDR, 0, "rst_mid_kdata");
      cyc(4);
      rd(KCTRL_ADDR, 1, "rst_reaccept");
      rd(KDATA_ADDR, 1, "rst_reaccept_kdata");
      ichk(0, "rst_mid_intr");
      repeat (400) begin
         int op;
         op = $urandom_range(0, 5);
         case (op)
            0: idle();
            1: rdm(KDATA_ADDR, "rand_kdata");
            2: rdm(KCTRL_ADDR, "rand_kctrl");
            3: wr($urandom);
            4: begin idle(); push("rand_intr", {31'b0, m_intr}, 1); end
            default: hiz($urandom_range(0, 1) ? KDATA_ADDR : 32'hF000_0200, 1'($urandom_range(0, 1)) | 1'b1, "rand_hiz");
         endcase
         if ($urandom_range(0, 3) == 0) KEY = 4'($urandom);
      end
      cyc(2);
      if (q.size() != 0) begin
         total++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
